// File: rtl/m_cache_refill.sv
`default_nettype none
// ============================================================================
// Module   : m_cache_refill
// Purpose  : Critical-word-first 4-beat line refill engine with early word
//            forwarding and a single-cycle install into a direct-mapped cache.
// Revision : 1.0
// ============================================================================
module m_cache_refill #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_miss,
  input  logic [ADDR_WIDTH-1:0] i_miss_addr,
  output logic                  o_miss_ready,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [31:0]           i_mem_rdata,
  output logic                  o_crit_valid,
  output logic [31:0]           o_crit_data,
  input  logic                  i_hold,
  output logic                  o_ie,
  output logic [ADDR_WIDTH-1:0] o_iaddr,
  output logic [127:0]          o_idata,
  output logic                  o_busy
);

  localparam int c_line_w = ADDR_WIDTH - 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_FILL    = 2'd2,
    S_INSTALL = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_line_w-1:0] r_line;
  logic [1:0]          r_w0;
  logic [1:0]          r_cnt;
  logic [127:0]        r_buf;
  logic [31:0]         r_crit_data;
  logic                r_crit_valid;
  logic                w_accept;
  logic                w_beat;
  logic [1:0]          w_slot;
  logic                w_unused;

  // Byte offset within the word carries no information for a word refill.
  assign w_unused = ^i_miss_addr[1:0];

  // Slot index wraps naturally in two bits, giving critical-word-first order.
  assign w_slot = r_w0 + r_cnt;

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_beat       = 1'b0;
    o_ie         = 1'b0;
    o_miss_ready = 1'b0;
    o_mem_req    = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_miss_ready = 1'b1;
        if (i_miss) begin
          w_accept    = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        o_mem_req = 1'b1;
        if (i_mem_gnt) w_state_nxt = S_FILL;
      end
      S_FILL: begin
        if (i_mem_rvalid) begin
          w_beat = 1'b1;
          if (r_cnt == 2'd3) w_state_nxt = S_INSTALL;
        end
      end
      S_INSTALL: begin
        o_ie = !i_hold;
        if (!i_hold) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_line       <= '0;
      r_w0         <= 2'd0;
      r_cnt        <= 2'd0;
      r_buf        <= '0;
      r_crit_data  <= 32'd0;
      r_crit_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_crit_valid <= w_beat && (r_cnt == 2'd0);
      if (w_accept) begin
        r_line <= i_miss_addr[ADDR_WIDTH-1:4];
        r_w0   <= i_miss_addr[3:2];
      end
      if (r_state == S_REQ && i_mem_gnt) r_cnt <= 2'd0;
      if (w_beat) begin
        r_buf[{w_slot, 5'b0} +: 32] <= i_mem_rdata;
        r_cnt                       <= r_cnt + 2'd1;
        if (r_cnt == 2'd0) r_crit_data <= i_mem_rdata;
      end
    end
  end

  assign o_mem_addr   = {r_line, r_w0, 2'b00};
  assign o_iaddr      = {r_line, 4'b0000};
  assign o_idata      = r_buf;
  assign o_crit_data  = r_crit_data;
  assign o_crit_valid = r_crit_valid;
  assign o_busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_m_cache_refill.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_cache_refill
// Purpose  : Self-checking bench for m_cache_refill against a line-level model.
// Revision : 1.0
// ============================================================================
module tb_m_cache_refill;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_miss = 1'b0;
  logic [31:0]  i_miss_addr = '0;
  logic         o_miss_ready;
  logic         o_mem_req;
  logic [31:0]  o_mem_addr;
  logic         i_mem_gnt = 1'b0;
  logic         i_mem_rvalid = 1'b0;
  logic [31:0]  i_mem_rdata = '0;
  logic         o_crit_valid;
  logic [31:0]  o_crit_data;
  logic         i_hold = 1'b0;
  logic         o_ie;
  logic [31:0]  o_iaddr;
  logic [127:0] o_idata;
  logic         o_busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  m_cache_refill #(.ADDR_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .o_miss_ready(o_miss_ready), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
    .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_crit_valid(o_crit_valid), .o_crit_data(o_crit_data), .i_hold(i_hold),
    .o_ie(o_ie), .o_iaddr(o_iaddr), .o_idata(o_idata), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic cycle();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    cycle(); cycle();
    total_cnt++; if (o_miss_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", o_miss_ready); else pass_cnt++;
    total_cnt++; if (o_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", o_busy); else pass_cnt++;
    total_cnt++; if (o_mem_req !== 1'b0 || o_mem_addr !== 32'h0) $display("FAIL rst_mem: got req=%b addr=%h want 0/0", o_mem_req, o_mem_addr); else pass_cnt++;
    total_cnt++; if (o_crit_valid !== 1'b0 || o_crit_data !== 32'h0) $display("FAIL rst_crit: got v=%b d=%h want 0/0", o_crit_valid, o_crit_data); else pass_cnt++;
    total_cnt++; if (o_ie !== 1'b0 || o_iaddr !== 32'h0 || o_idata !== 128'h0) $display("FAIL rst_install: got ie=%b a=%h d=%h want zeros", o_ie, o_iaddr, o_idata); else pass_cnt++;
    i_rst_n = 1'b1;
    cycle();
  endtask

  // One complete refill. The reference line is built from the rule
  // "beat k lands in word (w0+k) mod 4"; stray gnt/rvalid are injected
  // wherever the engine must ignore them.
  task automatic run_miss(input logic [31:0] addr, input int gnt_dly, input int gap_max,
                          input bit gap_rand, input int hold_n, input bit keep_miss,
                          input logic [31:0] next_addr, input bit chk_best);
    logic [31:0]  words [4];
    logic [127:0] exp_line;
    logic [31:0]  exp_maddr;
    logic [31:0]  exp_iaddr;
    logic         exp_cv;
    int           cyc;
    int           k;
    int           gap_left;
    exp_line  = '0;
    for (int j = 0; j < 4; j++) begin
      words[j] = $urandom;
      exp_line[((int'(addr[3:2]) + j) % 4) * 32 +: 32] = words[j];
    end
    exp_maddr = {addr[31:2], 2'b00};
    exp_iaddr = {addr[31:4], 4'b0000};

    i_miss = 1'b1;
    i_miss_addr = addr;
    #1;
    total_cnt++; if (o_miss_ready !== 1'b1) $display("FAIL accept_ready: got %b want 1", o_miss_ready); else pass_cnt++;
    cycle();
    cyc = 1;
    if (keep_miss) i_miss_addr = next_addr; else i_miss = 1'b0;

    for (int d = 0; d < gnt_dly; d++) begin
      total_cnt++; if (o_mem_req !== 1'b1 || o_mem_addr !== exp_maddr) $display("FAIL req_stable: got req=%b addr=%h want 1/%h", o_mem_req, o_mem_addr, exp_maddr); else pass_cnt++;
      total_cnt++; if (o_miss_ready !== 1'b0 || o_busy !== 1'b1) $display("FAIL req_busy: got ready=%b busy=%b want 0/1", o_miss_ready, o_busy); else pass_cnt++;
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = $urandom;
      cycle(); cyc++;
    end
    i_mem_rvalid = 1'b0;
    total_cnt++; if (o_mem_req !== 1'b1 || o_mem_addr !== exp_maddr) $display("FAIL req_at_gnt: got req=%b addr=%h want 1/%h", o_mem_req, o_mem_addr, exp_maddr); else pass_cnt++;
    i_mem_gnt = 1'b1;
    cycle(); cyc++;
    i_mem_gnt = 1'b0;
    total_cnt++; if (o_mem_req !== 1'b0) $display("FAIL req_drop: got %b want 0", o_mem_req); else pass_cnt++;

    k = 0;
    exp_cv = 1'b0;
    gap_left = gap_rand ? $urandom_range(gap_max, 0) : 0;
    while (k < 4) begin
      total_cnt++; if (o_crit_valid !== exp_cv) $display("FAIL crit_valid: got %b want %b (beat %0d)", o_crit_valid, exp_cv, k); else pass_cnt++;
      if (exp_cv) begin
        total_cnt++; if (o_crit_data !== words[0]) $display("FAIL crit_data: got %h want %h", o_crit_data, words[0]); else pass_cnt++;
      end
      total_cnt++; if (o_ie !== 1'b0) $display("FAIL ie_in_fill: got %b want 0", o_ie); else pass_cnt++;
      exp_cv = 1'b0;
      if (gap_left > 0) begin
        gap_left--;
        i_mem_rvalid = 1'b0;
        i_mem_gnt    = 1'($urandom_range(1, 0));
      end else begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = words[k];
        i_mem_gnt    = 1'b0;
        exp_cv       = (k == 0);
        k++;
        gap_left = gap_rand ? $urandom_range(gap_max, 0) : gap_max;
      end
      cycle(); cyc++;
    end
    i_mem_gnt = 1'b0;
    total_cnt++; if (o_crit_valid !== exp_cv) $display("FAIL crit_valid_end: got %b want %b", o_crit_valid, exp_cv); else pass_cnt++;

    for (int h = 0; h < hold_n; h++) begin
      i_hold = 1'b1;
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = $urandom;
      #1;
      total_cnt++; if (o_ie !== 1'b0 || o_busy !== 1'b1) $display("FAIL hold_ie: got ie=%b busy=%b want 0/1", o_ie, o_busy); else pass_cnt++;
      total_cnt++; if (o_idata !== exp_line) $display("FAIL hold_data: got %h want %h", o_idata, exp_line); else pass_cnt++;
      cycle(); cyc++;
    end
    i_hold = 1'b0;
    i_mem_rvalid = 1'b0;
    #1;
    total_cnt++; if (o_ie !== 1'b1) $display("FAIL ie_pulse: got %b want 1", o_ie); else pass_cnt++;
    total_cnt++; if (o_iaddr !== exp_iaddr) $display("FAIL iaddr: got %h want %h", o_iaddr, exp_iaddr); else pass_cnt++;
    total_cnt++; if (o_idata !== exp_line) $display("FAIL idata: got %h want %h", o_idata, exp_line); else pass_cnt++;
    if (chk_best) begin
      total_cnt++; if (cyc !== 6) $display("FAIL best_latency: got ie at T+%0d want T+6", cyc); else pass_cnt++;
    end
    cycle();
    total_cnt++; if (o_ie !== 1'b0) $display("FAIL ie_single: got %b want 0", o_ie); else pass_cnt++;
    total_cnt++; if (o_miss_ready !== 1'b1 || o_busy !== 1'b0) $display("FAIL back_idle: got ready=%b busy=%b want 1/0", o_miss_ready, o_busy); else pass_cnt++;
  endtask

  task automatic test_aligned();
    run_miss(32'h0000_1230, 0, 0, 1'b0, 0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_wrap();
    run_miss(32'h0000_123C, 0, 0, 1'b0, 0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_stalls();
    run_miss(32'h0000_5674, 3, 1, 1'b0, 0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_hold();
    run_miss(32'h0000_9AB8, 0, 0, 1'b0, 2, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid_fill();
    i_miss = 1'b1;
    i_miss_addr = 32'h0000_2004;
    cycle();
    i_miss = 1'b0;
    i_mem_gnt = 1'b1;
    cycle();
    i_mem_gnt = 1'b0;
    for (int b = 0; b < 2; b++) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = $urandom | 32'h1;
      cycle();
    end
    i_mem_rvalid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    total_cnt++; if (o_busy !== 1'b0 || o_miss_ready !== 1'b1) $display("FAIL mid_rst_state: got busy=%b ready=%b want 0/1", o_busy, o_miss_ready); else pass_cnt++;
    total_cnt++; if (o_crit_valid !== 1'b0 || o_crit_data !== 32'h0) $display("FAIL mid_rst_crit: got v=%b d=%h want 0/0", o_crit_valid, o_crit_data); else pass_cnt++;
    total_cnt++; if (o_mem_addr !== 32'h0 || o_iaddr !== 32'h0 || o_idata !== 128'h0) $display("FAIL mid_rst_regs: got ma=%h ia=%h d=%h want zeros", o_mem_addr, o_iaddr, o_idata); else pass_cnt++;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int b = 0; b < 2; b++) begin
      i_mem_rvalid = 1'b1;
      i_mem_gnt    = 1'b1;
      i_mem_rdata  = $urandom;
      cycle();
      total_cnt++; if (o_ie !== 1'b0 || o_busy !== 1'b0 || o_mem_req !== 1'b0) $display("FAIL stray_beat: got ie=%b busy=%b req=%b want 0/0/0", o_ie, o_busy, o_mem_req); else pass_cnt++;
      total_cnt++; if (o_miss_ready !== 1'b1 || o_crit_valid !== 1'b0 || o_idata !== 128'h0) $display("FAIL stray_state: got ready=%b cv=%b d=%h want 1/0/0", o_miss_ready, o_crit_valid, o_idata); else pass_cnt++;
    end
    i_mem_rvalid = 1'b0;
    i_mem_gnt    = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_miss(32'h0000_0040, 0, 0, 1'b0, 0, 1'b1, 32'h0000_0080, 1'b1);
    run_miss(32'h0000_0080, 1, 0, 1'b0, 0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      run_miss($urandom, $urandom_range(3, 0), 2, 1'b1, $urandom_range(2, 0), 1'b0, 32'h0, 1'b0);
      for (int idle = $urandom_range(2, 0); idle > 0; idle--) begin
        i_mem_rvalid = 1'($urandom_range(1, 0));
        cycle();
        total_cnt++; if (o_busy !== 1'b0 || o_ie !== 1'b0) $display("FAIL idle_stray: got busy=%b ie=%b want 0/0", o_busy, o_ie); else pass_cnt++;
      end
      i_mem_rvalid = 1'b0;
    end
  endtask

  initial begin
    @(negedge i_clk);
    test_reset();
    test_aligned();
    test_wrap();
    test_stalls();
    test_hold();
    test_reset_mid_fill();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
